// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point scaling controller:
// FSM state encoding, default geometry and the headroom-threshold helper.
package bfp_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int N_LOG2_DEF     = 6;
  localparam int NUM_STAGES_DEF = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STAGE = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // True when a sign-extended sample of width dw no longer has a spare guard bit,
  // i.e. x >= 2^(dw-2) or x < -2^(dw-2). Valid for dw <= 32.
  function automatic logic headroom_lost(input int x, input int dw);
    return (x >= (1 <<< (dw - 2))) || (x < -(1 <<< (dw - 2)));
  endfunction

endpackage

// File: rtl/bfp_scale_ctrl_headroom_det.sv
// Combinational headroom detector for one complex sample; shared with the
// datapath overflow monitor.
module bfp_headroom_det
  import bfp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     needs_scale
);

  assign needs_scale = headroom_lost(32'(in_re), DATA_W) |
                       headroom_lost(32'(in_im), DATA_W);

endmodule

// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scaling controller: tracks stage headroom and drives the
// next stage's 1-bit shift and the block exponent. Optional BFP_FORCE_SCALE_EN
// adds a force_scale input that forces shift=1 on every stage.
module bfp_scale_ctrl
  import bfp_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int N_LOG2     = N_LOG2_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int EXP_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef BFP_FORCE_SCALE_EN
  input  logic                          force_scale,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_re,
  input  logic signed [DATA_W-1:0]      in_im,
  output logic                          shift,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic [EXP_W-1:0]              block_exp,
  output logic                          busy,
  output logic                          done
);

  localparam int SIDX_W = $clog2(NUM_STAGES);

  logic [1:0]        state;
  logic [N_LOG2-1:0] count;
  logic              need_scale;
  logic              det_scale;
  logic              accept;
  logic              start_force;
  logic              force_q;
  logic              eval_scale;

  bfp_headroom_det #(.DATA_W(DATA_W)) u_det (
    .in_re       (in_re),
    .in_im       (in_im),
    .needs_scale (det_scale)
  );

`ifdef BFP_FORCE_SCALE_EN
  assign start_force = force_scale;

  always_ff @(posedge clk) begin
    if (rst)
      force_q <= 1'b0;
    else if (state == ST_IDLE && start)
      force_q <= force_scale;
  end
`else
  // NOTE: the feature-off build ties these to constants so the shared logic below needs no guards.
  assign start_force = 1'b0;
  assign force_q     = 1'b0;
`endif

  assign in_ready   = (state == ST_STAGE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign accept     = in_valid & in_ready;
  assign eval_scale = need_scale | force_q;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      need_scale <= 1'b0;
      shift      <= 1'b0;
      stage_idx  <= '0;
      block_exp  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_STAGE;
            count      <= '0;
            need_scale <= 1'b0;
            stage_idx  <= '0;
            // A forced transform shifts stage 0 as well, so it counts towards the exponent.
            shift      <= start_force;
            block_exp  <= EXP_W'(start_force);
          end
        end
        ST_STAGE: begin
          if (accept) begin
            need_scale <= need_scale | det_scale;
            if (count == '1) begin
              count <= '0;
              state <= (stage_idx == SIDX_W'(NUM_STAGES - 1)) ? ST_DONE : ST_EVAL;
            end else begin
              count <= count + N_LOG2'(1);
            end
          end
        end
        ST_EVAL: begin
          shift      <= eval_scale;
          block_exp  <= block_exp + EXP_W'(eval_scale);
          stage_idx  <= stage_idx + SIDX_W'(1);
          need_scale <= 1'b0;
          count      <= '0;
          state      <= ST_STAGE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
